// File: rtl/pc_pkg.sv
//------------------------------------------------------------------------------
// Module   : pc_pkg
// Brief    : Shared op encoding, priority encoder and alignment helpers for
//            the program-counter sequencer.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pc_pkg;

   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_UP   = 3'd1,
      OP_JUMP = 3'd2,
      OP_CALL = 3'd3,
      OP_RET  = 3'd4
   } op_e;

   // ret > call > jump > up
   function automatic op_e prio_encode(input logic up, input logic jump,
                                       input logic call, input logic ret);
      if (ret)       return OP_RET;
      else if (call) return OP_CALL;
      else if (jump) return OP_JUMP;
      else if (up)   return OP_UP;
      else           return OP_NONE;
   endfunction

   // Bits below the instruction step; cleared on jump/call targets.
   function automatic logic [63:0] low_mask(input int unsigned step);
      return 64'(step) - 64'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
//------------------------------------------------------------------------------
// Module   : pc_sequencer_if
// Brief    : Control/status bundle between the fetch controller and the
//            program-counter sequencer.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pc_sequencer_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int RAS_DEPTH  = 4
);
   localparam int c_cnt_w = $clog2(RAS_DEPTH) + 1;

   logic                  clear;
   logic                  hold;
   logic                  up;
   logic                  jump;
   logic                  call;
   logic                  ret;
   logic                  err_clr;
   logic [ADDR_WIDTH-1:0] target;
   logic [ADDR_WIDTH-1:0] address;
   logic [c_cnt_w-1:0]    ras_count;
   logic                  ras_empty;
   logic                  ras_full;
   logic                  ras_ovf;
   logic                  ras_unf;

   modport master (
      output clear, hold, up, jump, call, ret, err_clr, target,
      input  address, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
   );

   modport slave (
      input  clear, hold, up, jump, call, ret, err_clr, target,
      output address, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
   );

endinterface

`default_nettype wire

// File: rtl/return_addr_stack.sv
//------------------------------------------------------------------------------
// Module   : return_addr_stack
// Brief    : Circular return-address stack; overwrites the oldest entry when
//            full and saturates its occupancy count.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module return_addr_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   localparam int c_ptr_w = $clog2(DEPTH),
   localparam int c_cnt_w = c_ptr_w + 1
) (
   input  logic               clock,
   input  logic               clear_n,
   input  logic               clear,
   input  logic               push,
   input  logic               pop,
   input  logic [WIDTH-1:0]   push_data,
   output logic [WIDTH-1:0]   top_data,
   output logic [c_cnt_w-1:0] count
);

   localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

   logic [c_ptr_w-1:0] ptr_q, ptr_d;
   logic [c_cnt_w-1:0] count_q, count_d;
   logic               wr_en;
   logic [WIDTH-1:0]   mem_q [DEPTH];

   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      wr_en   = 1'b0;
      if (clear) begin
         ptr_d   = '0;
         count_d = '0;
      end else if (push) begin
         // Pointer wraps naturally, so a push when full lands on the oldest slot.
         ptr_d = ptr_q + 1'b1;
         wr_en = 1'b1;
         if (count_q != c_full) begin
            count_d = count_q + 1'b1;
         end
      end else if (pop && (count_q != '0)) begin
         ptr_d   = ptr_q - 1'b1;
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[ptr_d] <= push_data;
      end
   end

   assign top_data = mem_q[ptr_q];
   assign count    = count_q;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// Module   : pc_sequencer
// Brief    : Registered instruction-fetch address with up/jump/call/ret,
//            stall, synchronous clear and sticky return-stack error flags.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
   import pc_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    STEP       = 4,
   parameter int                    RAS_DEPTH  = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
   input  logic          clock,
   input  logic          clear_n,
   pc_sequencer_if.slave bus
);

   localparam int                    c_cnt_w      = $clog2(RAS_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] c_step       = ADDR_WIDTH'(STEP);
   localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~ADDR_WIDTH'(low_mask(STEP));
   localparam logic [c_cnt_w-1:0]    c_full       = c_cnt_w'(RAS_DEPTH);

   logic [ADDR_WIDTH-1:0] address_q, address_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  push, pop;
   logic [ADDR_WIDTH-1:0] next_seq;
   logic [ADDR_WIDTH-1:0] target_aligned;
   logic [ADDR_WIDTH-1:0] ras_top;
   logic [c_cnt_w-1:0]    ras_count;
   logic                  ras_empty;
   logic                  ras_full;
   op_e                   op;

   assign op             = prio_encode(bus.up, bus.jump, bus.call, bus.ret);
   assign next_seq       = address_q + c_step;
   assign target_aligned = bus.target & c_align_mask;
   assign ras_empty      = (ras_count == '0);
   assign ras_full       = (ras_count == c_full);

   always_comb begin
      address_d = address_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      push      = 1'b0;
      pop       = 1'b0;
      if (bus.clear) begin
         address_d = RESET_ADDR;
         ovf_d     = 1'b0;
         unf_d     = 1'b0;
      end else if (!bus.hold) begin
         // Clear first so a same-cycle error sets the flag again below.
         if (bus.err_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
         end
         case (op)
            OP_UP:   address_d = next_seq;
            OP_JUMP: address_d = target_aligned;
            OP_CALL: begin
               push      = 1'b1;
               address_d = target_aligned;
               if (ras_full) begin
                  ovf_d = 1'b1;
               end
            end
            OP_RET: begin
               if (ras_empty) begin
                  address_d = next_seq;
                  unf_d     = 1'b1;
               end else begin
                  pop       = 1'b1;
                  address_d = ras_top;
               end
            end
            default: address_d = address_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         address_q <= RESET_ADDR;
         ovf_q     <= 1'b0;
         unf_q     <= 1'b0;
      end else begin
         address_q <= address_d;
         ovf_q     <= ovf_d;
         unf_q     <= unf_d;
      end
   end

   return_addr_stack #(
      .WIDTH (ADDR_WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clock     (clock),
      .clear_n   (clear_n),
      .clear     (bus.clear),
      .push      (push),
      .pop       (pop),
      .push_data (next_seq),
      .top_data  (ras_top),
      .count     (ras_count)
   );

   assign bus.address   = address_q;
   assign bus.ras_count = ras_count;
   assign bus.ras_empty = ras_empty;
   assign bus.ras_full  = ras_full;
   assign bus.ras_ovf   = ovf_q;
   assign bus.ras_unf   = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_pc_sequencer
// Brief    : Scoreboard bench for pc_sequencer with a queue-based stack model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;

   typedef struct {
      logic [15:0] addr;
      logic [2:0]  cnt;
      logic        ovf;
      logic        unf;
   } exp_t;

   logic clock;
   logic clear_n;
   int   n_vec;
   int   n_err;

   exp_t        sb_q[$];
   logic [15:0] m_addr;
   logic [15:0] m_stk[$];
   logic        m_ovf;
   logic        m_unf;

   pc_sequencer_if #(.ADDR_WIDTH(16), .RAS_DEPTH(4)) bus ();

   pc_sequencer #(
      .ADDR_WIDTH (16),
      .STEP       (4),
      .RAS_DEPTH  (4),
      .RESET_ADDR (16'h0000)
   ) dut (
      .clock   (clock),
      .clear_n (clear_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_addr = 16'h0000;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic idle();
      bus.clear   = 1'b0;
      bus.hold    = 1'b0;
      bus.up      = 1'b0;
      bus.jump    = 1'b0;
      bus.call    = 1'b0;
      bus.ret     = 1'b0;
      bus.err_clr = 1'b0;
      bus.target  = 16'h0000;
   endtask

   task automatic check_outputs(input exp_t e);
      chk("address",   32'(bus.address),   32'(e.addr));
      chk("ras_count", 32'(bus.ras_count), 32'(e.cnt));
      chk("ras_ovf",   32'(bus.ras_ovf),   32'(e.ovf));
      chk("ras_unf",   32'(bus.ras_unf),   32'(e.unf));
      chk("ras_empty", 32'(bus.ras_empty), 32'(e.cnt == 3'd0));
      chk("ras_full",  32'(bus.ras_full),  32'(e.cnt == 3'd4));
   endtask

   task automatic drive(input bit clr, input bit hld, input bit u, input bit j,
                        input bit c, input bit r, input bit ec, input logic [15:0] tgt);
      exp_t e;
      @(negedge clock);
      bus.clear = clr; bus.hold = hld; bus.up = u; bus.jump = j;
      bus.call = c; bus.ret = r; bus.err_clr = ec; bus.target = tgt;
      if (clr) begin
         model_reset();
      end else if (!hld) begin
         if (ec) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
         end
         if (r) begin
            if (m_stk.size() > 0) begin
               m_addr = m_stk.pop_back();
            end else begin
               m_addr = m_addr + 16'd4;
               m_unf  = 1'b1;
            end
         end else if (c) begin
            m_stk.push_back(m_addr + 16'd4);
            if (m_stk.size() > 4) begin
               void'(m_stk.pop_front());
               m_ovf = 1'b1;
            end
            m_addr = tgt & 16'hFFFC;
         end else if (j) begin
            m_addr = tgt & 16'hFFFC;
         end else if (u) begin
            m_addr = m_addr + 16'd4;
         end
      end
      e.addr = m_addr;
      e.cnt  = 3'(m_stk.size());
      e.ovf  = m_ovf;
      e.unf  = m_unf;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      e = sb_q.pop_front();
      check_outputs(e);
   endtask

   task automatic async_reset_mid_cycle();
      @(posedge clock);
      #3;
      clear_n = 1'b0;
      #1;
      model_reset();
      chk("async_address", 32'(bus.address), 32'h0);
      chk("async_count",   32'(bus.ras_count), 32'h0);
      idle();
      @(negedge clock);
      clear_n = 1'b1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      idle();
      model_reset();
      clear_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_address", 32'(bus.address), 32'h0);
      chk("reset_count",   32'(bus.ras_count), 32'h0);
      chk("reset_ovf",     32'(bus.ras_ovf), 32'h0);
      chk("reset_unf",     32'(bus.ras_unf), 32'h0);
      chk("reset_empty",   32'(bus.ras_empty), 32'h1);
      @(negedge clock);
      clear_n = 1'b1;

      // up x3 -> 4, 8, 12; then async reset mid-cycle
      repeat (3) drive(0, 0, 1, 0, 0, 0, 0, 16'h0);
      async_reset_mid_cycle();

      // jump alignment, then up+jump together
      drive(0, 0, 0, 1, 0, 0, 0, 16'h0103);
      drive(0, 0, 0, 0, 0, 0, 0, 16'h0);
      drive(0, 0, 1, 1, 0, 0, 0, 16'h0103);

      // single call/ret from 0x0010
      drive(0, 0, 0, 1, 0, 0, 0, 16'h0010);
      drive(0, 0, 0, 0, 1, 0, 0, 16'h0200);
      drive(0, 0, 0, 0, 0, 1, 0, 16'h0);

      // 5 nested calls overflow a depth-4 stack, then 4 LIFO returns
      for (int i = 1; i <= 5; i++) drive(0, 0, 0, 0, 1, 0, 0, 16'(i * 16'h1000 + 16'h0002));
      for (int i = 0; i < 4; i++)  drive(0, 0, 0, 0, 0, 1, 0, 16'h0);

      // empty-stack ret, err_clr, hold behaviour
      drive(0, 0, 0, 1, 0, 0, 0, 16'h0040);
      drive(0, 0, 0, 0, 0, 1, 0, 16'h0);
      drive(0, 0, 0, 0, 0, 0, 1, 16'h0);
      drive(0, 1, 0, 0, 0, 1, 0, 16'h0);
      drive(0, 0, 0, 0, 0, 1, 0, 16'h0);
      drive(0, 1, 0, 0, 0, 0, 1, 16'h0);
      drive(0, 0, 0, 0, 0, 1, 1, 16'h0);

      // wrap: up at 0xFFFC, and a call whose return address wraps
      drive(0, 0, 0, 1, 0, 0, 0, 16'hFFFC);
      drive(0, 0, 1, 0, 0, 0, 0, 16'h0);
      drive(0, 0, 0, 1, 0, 0, 0, 16'hFFFC);
      drive(0, 0, 0, 0, 1, 0, 0, 16'h0300);
      drive(0, 0, 0, 0, 0, 1, 0, 16'h0);

      // clear priority over call, hold and err_clr
      drive(0, 0, 0, 0, 1, 0, 0, 16'h0400);
      drive(0, 0, 0, 0, 0, 1, 0, 16'h0);
      drive(0, 0, 0, 0, 0, 1, 0, 16'h0);
      drive(0, 0, 0, 0, 1, 0, 0, 16'h0500);
      drive(1, 1, 0, 0, 1, 0, 1, 16'h0600);

      // randomised mix
      for (int i = 0; i < 300; i++) begin
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 1) == 0,  $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0,  $urandom_range(0, 3) == 0,
               $urandom_range(0, 5) == 0,  16'($urandom));
      end
      async_reset_mid_cycle();
      drive(0, 0, 1, 0, 0, 0, 0, 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
